// File: rtl/motor_feedback_decoder.sv
// Hall-sensor feedback decoder: synchronises and glitch-filters SA/SB, counts SA rising edges per window.
// Optional stall flag is enabled with `define MOTOR_FB_STALL_EN.
module motor_feedback_decoder #(
   parameter int WIDTH         = 12,
   parameter int WINDOW_CYCLES = 100000,
   parameter int FILTER_LEN    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sa_in,
   input  logic             sb_in,
   output logic [WIDTH-1:0] edge_count_out,
   output logic             dir_out,
   output logic             count_valid_out,
   output logic             overflow_out,
   output logic             stall_out
);

   localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
   localparam logic [WIDTH-1:0] ACC_MAX  = '1;

   // Channel index 0 = SA, 1 = SB
   logic [1:0]            r_s1;
   logic [1:0]            r_s2;
   logic [1:0]            r_filt;
   logic [1:0][RUN_W-1:0] r_run;
   logic                  r_sa_prev;

   logic [WIDTH-1:0] r_acc;
   logic             r_sticky;
   logic [WIN_W-1:0] r_win;

   logic             w_edge;
   logic             w_tc;
   logic             w_at_max;
   logic             w_sat_now;
   logic [WIDTH-1:0] w_acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_filt    <= '0;
         r_run     <= '0;
         r_sa_prev <= 1'b0;
      end else begin
         r_s1      <= {sb_in, sa_in};
         r_s2      <= r_s1;
         r_sa_prev <= r_filt[0];
         for (int ch = 0; ch < 2; ch++) begin
            // Level flips on the FILTER_LEN-th consecutive opposite sample
            if (r_s2[ch] != r_filt[ch]) begin
               if (r_run[ch] == RUN_LAST) begin
                  r_filt[ch] <= r_s2[ch];
                  r_run[ch]  <= '0;
               end else begin
                  r_run[ch]  <= r_run[ch] + RUN_W'(1);
               end
            end else begin
               r_run[ch] <= '0;
            end
         end
      end
   end

   assign w_edge     = r_filt[0] & ~r_sa_prev;
   assign w_tc       = (r_win == WIN_LAST);
   assign w_at_max   = (r_acc == ACC_MAX);
   assign w_sat_now  = w_edge & w_at_max;
   assign w_acc_next = (w_edge && !w_at_max) ? r_acc + WIDTH'(1) : r_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc           <= '0;
         r_sticky        <= 1'b0;
         r_win           <= '0;
         edge_count_out  <= '0;
         dir_out         <= 1'b0;
         count_valid_out <= 1'b0;
         overflow_out    <= 1'b0;
      end else begin
         if (w_edge)
            dir_out <= ~r_filt[1];
         if (w_tc) begin
            // Closing window includes an edge strobe landing on its last cycle
            r_win           <= '0;
            edge_count_out  <= w_acc_next;
            overflow_out    <= r_sticky | w_sat_now;
            count_valid_out <= 1'b1;
            r_acc           <= '0;
            r_sticky        <= 1'b0;
         end else begin
            r_win           <= r_win + WIN_W'(1);
            count_valid_out <= 1'b0;
            r_acc           <= w_acc_next;
            r_sticky        <= r_sticky | w_sat_now;
         end
      end
   end

`ifdef MOTOR_FB_STALL_EN
   logic r_stall;

   always_ff @(posedge clk) begin
      if (reset)
         r_stall <= 1'b0;
      else if (w_tc)
         r_stall <= (w_acc_next == '0);
   end

   assign stall_out = r_stall;
`else
   assign stall_out = 1'b0;
`endif

endmodule

// File: doc/motor_feedback_decoder.md
# motor_feedback_decoder

Hall-sensor feedback decoder for the PmodHB3 motor path. It is the measurement counterpart of the PWM motor-enable generator. It synchronises and glitch-filters the SA/SB quadrature outputs and counts SA rising edges over a fixed sample window. At each window end it reports edge count, rotation direction and overflow to the software-visible register block.

## Interface
- WIDTH, 12 — width of edge_count_out; accumulator saturates at 2^WIDTH-1.
- WINDOW_CYCLES, 100000 — sample window length in clk cycles; must be ≥ 2.
- FILTER_LEN, 4 — consecutive equal synchronised samples required to accept a level change; must be ≥ 1.

- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sa_in  input  1  hall sensor A, asynchronous.
- sb_in  input  1  hall sensor B, asynchronous.
- edge_count_out  output  WIDTH  SA rising edges in last completed window.
- dir_out  output  1  1 = forward (SB low at SA rise), 0 = reverse.
- count_valid_out  output  1  one-cycle pulse when edge_count_out updates.
- overflow_out  output  1  last completed window saturated.
- stall_out  output  1  last completed window had zero edges (see Configuration).

## Operation
- Synchroniser: two-flop chain per input (s1, s2).
- Glitch filter, per channel:
  - Run counter compares s2 against the filtered level.
  - The filtered level flips after FILTER_LEN consecutive samples opposite to it.
  - Any matching sample clears the run counter.
- Edge detect: filtered SA high and previous filtered SA low gives one-cycle edge strobe.
- On each edge strobe:
  - Accumulator += 1, saturating at 2^WIDTH-1.
  - Overflow sticky flag set if already at max.
  - dir_out <= ~filtered SB.
- Window counter runs 0..WINDOW_CYCLES-1 and wraps; its width is $clog2(WINDOW_CYCLES).
- At terminal count (WINDOW_CYCLES-1):
  - edge_count_out <= accumulator including any edge strobe in this cycle (saturated).
  - overflow_out <= sticky flag, also OR'd with saturation caused by this cycle's edge.
  - count_valid_out <= 1 for exactly one cycle.
  - Accumulator and sticky flag cleared to 0.
- States: the block is a free-running window counter with no handshake. count_valid_out is informational and is not back-pressured.

## Timing
- Reset values: edge_count_out 0, dir_out 0, count_valid_out 0, overflow_out 0, stall_out 0.
- Reset also clears synchronisers, filtered levels (low), run counters, accumulator, sticky flag and window counter.
- Reset mid-window: the partial window is discarded and no valid pulse occurs. The first count_valid_out occurs WINDOW_CYCLES cycles after the last reset cycle.
- Latency, with sa_in first sampled high at edge n:
  - s2 high at n+1.
  - Filtered SA high after edge n+1+FILTER_LEN.
  - Accumulator increments at edge n+2+FILTER_LEN.
- dir_out updates on the same edge as the accumulator increment.
- Edge strobe coinciding with terminal count: counted in the closing window; the next window starts at 0.
- Pulses on sa_in shorter than FILTER_LEN cycles, after synchronisation, are never counted.
- Outputs edge_count_out, overflow_out and stall_out hold between valid pulses.

## Configuration
- MOTOR_FB_STALL_EN defined:
  - At each terminal count, stall_out <= (closing count == 0).
  - stall_out holds until the next terminal count.
- MOTOR_FB_STALL_EN undefined: stall_out tied to 0 and no stall logic is synthesised.

## Test plan
Bench parameters: WIDTH=12, WINDOW_CYCLES=1000, FILTER_LEN=4 unless noted.
- Reset held 5 cycles, inputs low, then released.
  - Required: all outputs 0.
  - Required: count_valid_out pulses exactly 1000 cycles after release with edge_count_out 0.
- SA square wave with 40-cycle period, SB lagging SA by 10 cycles, over a full window.
  - Required: edge_count_out 25, dir_out 1.
  - With SB leading instead: dir_out 0.
- Glitch filtering:
  - 3-cycle SA high pulse: not counted (count 0).
  - 4-cycle high pulse followed by ≥4 low: counted (count 1).
- Saturation with WIDTH=4 and 20 clean edges in one window.
  - Required: edge_count_out 15, overflow_out 1.
  - Required: the following clean window with 3 edges gives count 3, overflow_out 0.
- Terminal-count coincidence: edge strobe forced on window cycle 999.
  - Required: it is counted in the closing window.
  - Required: the next window reports only its own edges.
- Stall flag:
  - With MOTOR_FB_STALL_EN and no SA activity: stall_out 1 after the first window; one later window with ≥1 edge clears it.
  - Without the macro: stall_out stays 0.
